// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning architectural HI/LO, with a fixed-latency busy counter.
// Optional feature macro MD_MADD_EN: enables madd/msub (signed 64-bit accumulate into {hi,lo}).
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MSUB  = 4'd8
  } md_op_e;

  // What the commit edge does with the pending 64-bit value.
  typedef enum logic [1:0] {
    CM_NONE,
    CM_SET,
    CM_ADD,
    CM_SUB
  } commit_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_pend;
  commit_e     r_mode;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_zero;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  logic        w_launch;
  logic [3:0]  w_cnt_load;
  logic [63:0] w_pend_next;
  commit_e     w_mode_next;
  logic        w_wr_hi;
  logic        w_wr_lo;

  // The low 64 bits of a product are the same for signed and unsigned operands once sign-extended.
  assign w_prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign w_prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Signed divide on magnitudes so 0x8000_0000 / -1 wraps to 0x8000_0000 without overflow.
  assign w_div_zero = (rt_data == 32'd0);
  assign w_abs_a    = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
  assign w_abs_b    = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
  assign w_sq_mag   = w_div_zero ? 32'd0 : (w_abs_a / w_abs_b);
  assign w_sr_mag   = w_div_zero ? 32'd0 : (w_abs_a % w_abs_b);
  assign w_sq       = (rs_data[31] ^ rt_data[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr       = rs_data[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
  assign w_uq       = w_div_zero ? 32'd0 : (rs_data / rt_data);
  assign w_ur       = w_div_zero ? 32'd0 : (rs_data % rt_data);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_launch    = 1'b0;
    w_cnt_load  = 4'd0;
    w_pend_next = 64'd0;
    w_mode_next = CM_NONE;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    if (start && !r_busy) begin
      case (md_op)
        OP_MULT: begin
          w_launch    = 1'b1;
          w_cnt_load  = MULT_LOAD;
          w_pend_next = w_prod_s;
          w_mode_next = CM_SET;
        end
        OP_MULTU: begin
          w_launch    = 1'b1;
          w_cnt_load  = MULT_LOAD;
          w_pend_next = w_prod_u;
          w_mode_next = CM_SET;
        end
        OP_DIV: begin
          w_launch    = 1'b1;
          w_cnt_load  = DIV_LOAD;
          w_pend_next = {w_sr, w_sq};
          w_mode_next = w_div_zero ? CM_NONE : CM_SET;
        end
        OP_DIVU: begin
          w_launch    = 1'b1;
          w_cnt_load  = DIV_LOAD;
          w_pend_next = {w_ur, w_uq};
          w_mode_next = w_div_zero ? CM_NONE : CM_SET;
        end
        OP_MTHI: w_wr_hi = 1'b1;
        OP_MTLO: w_wr_lo = 1'b1;
`ifdef MD_MADD_EN
        OP_MADD: begin
          w_launch    = 1'b1;
          w_cnt_load  = MULT_LOAD;
          w_pend_next = w_prod_s;
          w_mode_next = CM_ADD;
        end
        OP_MSUB: begin
          w_launch    = 1'b1;
          w_cnt_load  = MULT_LOAD;
          w_pend_next = w_prod_s;
          w_mode_next = CM_SUB;
        end
`else
`endif
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_cnt  <= 4'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      // NOTE: the pending result is reset too, so an aborted operation leaves nothing behind.
      r_pend <= 64'd0;
      r_mode <= CM_NONE;
    end else if (r_busy) begin
      if (r_cnt == 4'd0) begin
        r_busy <= 1'b0;
        r_mode <= CM_NONE;
        case (r_mode)
          CM_SET:  {r_hi, r_lo} <= r_pend;
          CM_ADD:  {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
          CM_SUB:  {r_hi, r_lo} <= {r_hi, r_lo} - r_pend;
          default: ;
        endcase
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end else if (w_launch) begin
      r_busy <= 1'b1;
      r_cnt  <= w_cnt_load;
      r_pend <= w_pend_next;
      r_mode <= w_mode_next;
    end else begin
      if (w_wr_hi) r_hi <= rs_data;
      if (w_wr_lo) r_lo <= rs_data;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit; a high-level model predicts HI/LO/busy, a monitor checks commits.
// Honours MD_MADD_EN the same way as the design.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } sb_item_t;

  sb_item_t    sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          free_at  = 0;
  logic [31:0] m_hi     = 32'd0;
  logic [31:0] m_lo     = 32'd0;
  logic        prev_busy = 1'b0;
  int          busy_len  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] f_smul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_;
    sa  = $signed(a);
    sb_ = $signed(b);
    return 64'(sa * sb_);
  endfunction

  function automatic logic [63:0] f_sdiv(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    sa  = $signed(a);
    sb_ = $signed(b);
    q   = sa / sb_;
    r   = sa % sb_;
    return {r[31:0], q[31:0]};
  endfunction

  // Model of one issue attempt landing on edge k.
  task automatic model_accept(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    sb_item_t it;
    if (k < free_at) return;
    it.hi = m_hi;
    it.lo = m_lo;
    it.n  = 0;
    case (op)
      4'd1: begin {it.hi, it.lo} = f_smul(a, b); it.n = MC; end
      4'd2: begin {it.hi, it.lo} = {32'd0, a} * {32'd0, b}; it.n = MC; end
      4'd3: begin if (b != 0) {it.hi, it.lo} = f_sdiv(a, b); it.n = DC; end
      4'd4: begin if (b != 0) begin it.lo = a / b; it.hi = a % b; end it.n = DC; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
`ifdef MD_MADD_EN
      4'd7: begin {it.hi, it.lo} = {m_hi, m_lo} + f_smul(a, b); it.n = MC; end
      4'd8: begin {it.hi, it.lo} = {m_hi, m_lo} - f_smul(a, b); it.n = MC; end
`endif
      default: ;
    endcase
    if (it.n != 0) begin
      sb.push_back(it);
      free_at = k + it.n + 1;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    @(negedge clk);
    start   = 1'b1;
    md_op   = op;
    rs_data = a;
    rt_data = b;
    k = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_accept(k, op, a, b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cyc + 1 >= free_at) break;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    free_at = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Monitor: every cycle compares visible state with the model; pops the scoreboard when busy falls.
  always @(negedge clk) begin
    sb_item_t it;
    if (!reset) begin
      prev_busy = 1'b0;
      busy_len  = 0;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
    end else begin
      if (busy) busy_len++;
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          check("commit_unexpected", 64'd1, 64'd0);
        end else begin
          it = sb.pop_front();
          check("commit_len", 64'(busy_len), 64'(it.n));
          check("commit_hi", {32'd0, hi}, {32'd0, it.hi});
          check("commit_lo", {32'd0, lo}, {32'd0, it.lo});
          m_hi = it.hi;
          m_lo = it.lo;
        end
        busy_len = 0;
      end
      check("busy", {63'd0, busy}, {63'd0, (cyc + 1 < free_at)});
      check("hi", {32'd0, hi}, {32'd0, m_hi});
      check("lo", {32'd0, lo}, {32'd0, m_lo});
      prev_busy = busy;
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    reset   = 1'b0;
    start   = 1'b0;
    md_op   = 4'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check("tp_reset", {31'd0, busy, hi, lo}, 96'd0);

    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("tp_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("tp_multu", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("tp_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd4, 32'd7, 32'd2);
    wait_idle();
    check("tp_divu", {hi, lo}, 64'h0000_0001_0000_0003);

    issue(4'd5, 32'h11, 32'd0);
    issue(4'd6, 32'h22, 32'd0);
    issue(4'd3, 32'd1234, 32'd0);
    wait_idle();
    check("tp_div0", {hi, lo}, 64'h0000_0011_0000_0022);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("tp_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    issue(4'd5, 32'hDEAD_BEEF, 32'd0);
    check("tp_mthi_same_edge", {31'd0, busy, hi}, {32'd0, 32'hDEAD_BEEF});

    issue(4'd1, 32'd3, 32'd4);
    issue(4'd6, 32'h55, 32'd0);
    issue(4'd1, 32'd9, 32'd9);
    issue(4'd6, 32'h66, 32'd0);
    issue(4'd4, 32'd8, 32'd3);
    issue(4'd6, 32'h77, 32'd0);
    issue(4'd5, 32'hABCD, 32'd0);
    check("tp_ignore_busy", {hi, lo}, 64'h0000_ABCD_0000_000C);

    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd7, 32'd1, 32'd1);
`ifdef MD_MADD_EN
    check("tp_madd_busy", {63'd0, busy}, 64'd1);
    wait_idle();
    check("tp_madd", {hi, lo}, 64'h0000_0001_0000_0000);
`else
    check("tp_madd_busy", {63'd0, busy}, 64'd0);
    wait_idle();
    check("tp_madd", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    issue(4'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("tp_rst_mid_busy", {63'd0, busy}, 64'd1);
    do_reset();
    repeat (15) @(negedge clk);
    check("tp_rst_no_commit", {31'd0, busy, hi, lo}, 96'd0);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(9, 15));
      else op = 4'($urandom_range(0, 8));
      issue(op, rand_operand(), rand_operand());
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
